// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl
//   Time-multiplexed scan controller for a common-anode seven-segment display.
//   It steps through NDIGITS digit slots of DIV cycles each and presents one
//   nibble per slot to a downstream hex-to-segment decoder. The last GUARD
//   cycles of every slot keep all anodes off so the previous digit does not
//   ghost onto the next one. A captured value only becomes visible at a frame
//   boundary, so a frame is never shown half old and half new. Optional
//   leading-zero blanking darkens the unused upper digits.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; clears all state
//   enable      0 keeps the display dark, but scanning continues
//   lzb_en      enables leading-zero blanking
//   load        one-cycle strobe that captures value into the shadow register
//   value       4*NDIGITS-bit display value; digit i is value[4i+3:4i]
//   hex         nibble for the current digit (valid even while dark)
//   blank       1 forces all segments off
//   an          active-low one-hot digit enable
//   frame_tick  one-cycle pulse when the digit-0 slot of a new frame starts
module hex_scan_ctrl #(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned DIV     = 50000,
  parameter int unsigned GUARD   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   lzb_en,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   value,
  output logic [3:0]             hex,
  output logic                   blank,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST    = CW'(DIV - 1);
  localparam logic [DW-1:0] DIG_LAST    = DW'(NDIGITS - 1);
  // One extra bit so DIV itself (GUARD = 0) is representable; the compare
  // against it then never fires.
  localparam logic [CW:0]   GUARD_START = (CW + 1)'(DIV - GUARD);

  // S_ARM is the single cycle after reset release: counters hold at zero and
  // the outputs keep their reset values, so digit 0 appears on the second edge.
  typedef enum logic {
    S_ARM  = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [DW-1:0]           dig_q;
  logic [4*NDIGITS-1:0]    shadow_q;
  logic [4*NDIGITS-1:0]    disp_q;
  logic                    pending_q;
  logic                    first_frame_q;

  logic [3:0]              hex_q;
  logic                    blank_q;
  logic [NDIGITS-1:0]      an_q;
  logic                    frame_tick_q;

  logic [3:0]              hex_d;
  logic                    blank_d;
  logic [NDIGITS-1:0]      an_d;
  logic                    frame_tick_d;

  logic                    slot_end;
  logic                    frame_end;
  logic                    in_guard;
  logic                    lz_blank;
  logic                    lit;

  assign hex        = hex_q;
  assign blank      = blank_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (dig_q == DIG_LAST);
    in_guard  = ({1'b0, cnt_q} >= GUARD_START);

    hex_d    = '0;
    lz_blank = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (dig_q == DW'(i)) begin
        hex_d = disp_q[4*i +: 4];
        // Digit i is a leading zero when it and every digit above it are zero;
        // digit 0 is excluded so an all-zero value still shows one "0".
        if ((i != 0) && ((disp_q >> (4*i)) == '0)) begin
          lz_blank = lzb_en;
        end
      end
    end

    lit     = enable && !in_guard && !lz_blank;
    blank_d = !lit;
    an_d    = '1;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (lit && (dig_q == DW'(i))) begin
        an_d[i] = 1'b0;
      end
    end

    frame_tick_d = (cnt_q == '0) && (dig_q == '0) && !first_frame_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_ARM;
      cnt_q         <= '0;
      dig_q         <= '0;
      shadow_q      <= '0;
      disp_q        <= '0;
      pending_q     <= 1'b0;
      first_frame_q <= 1'b1;
      hex_q         <= '0;
      blank_q       <= 1'b1;
      an_q          <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      case (state_q)
        S_ARM: begin
          state_q      <= S_SCAN;
          hex_q        <= '0;
          blank_q      <= 1'b1;
          an_q         <= '1;
          frame_tick_q <= 1'b0;
        end
        default: begin
          hex_q        <= hex_d;
          blank_q      <= blank_d;
          an_q         <= an_d;
          frame_tick_q <= frame_tick_d;

          cnt_q <= slot_end ? '0 : cnt_q + 1'b1;
          if (slot_end) begin
            dig_q <= (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
          end
          if (frame_end) begin
            first_frame_q <= 1'b0;
            if (pending_q) begin
              disp_q    <= shadow_q;
              pending_q <= 1'b0;
            end
          end
        end
      endcase

      // Placed last so a load on the boundary cycle keeps pending set while
      // disp takes the previous shadow contents above.
      if (load) begin
        shadow_q  <= value;
        pending_q <= 1'b1;
      end
    end
  end

endmodule
